// File: rtl/mem_access_ctrl.sv
// Memory access controller in front of a synchronous-read RAM: owns MAR/MDR and sequences
// a single read or write per request, with optional read wait states.
module mem_access_ctrl #(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_W      = 9
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              req,
  input  logic              rw,
  output logic              busy,
  output logic              done,
  output logic [31:0]       MDR_out,
  output logic [ADDR_W-1:0] MAR_out,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_read,
  output logic              ram_write,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdWait,
    StRdData,
    StWr,
    StDone
  } state_e;

  localparam logic [3:0] WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [3:0]        cnt_q, cnt_d;

  // Address wraps by truncation; the upper bus bits are deliberately dropped.
  logic unused_bus;
  assign unused_bus = ^bus_in[31:ADDR_W];

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q <= StIdle;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    cnt_d     = cnt_q;
    busy      = 1'b1;
    done      = 1'b0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    case (state_q)
      StIdle: begin
        busy = 1'b0;
        // Loads land on the same edge as req, so the access uses the new values.
        if (MARin) mar_d = bus_in[ADDR_W-1:0];
        if (MDRin) mdr_d = bus_in;
        if (req)   state_d = rw ? StWr : StRdAddr;
      end
      StRdAddr: begin
        ram_read = 1'b1;
        if (WAIT_STATES == 0) begin
          state_d = StRdData;
        end else begin
          cnt_d   = WaitInit;
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        if (cnt_q == 4'd0) state_d = StRdData;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StRdData: begin
        mdr_d   = ram_rdata;
        state_d = StDone;
      end
      StWr: begin
        ram_write = 1'b1;
        state_d   = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign MDR_out   = mdr_q;
  assign MAR_out   = mar_q;
  assign ram_addr  = mar_q;
  assign ram_wdata = mdr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances (0, 2, 3 wait states) share stimulus, each with
// its own RAM model; done pulses are checked against a per-instance scoreboard.
module tb_mem_access_ctrl;

  localparam int NDUT = 3;
  localparam int AW   = 9;

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : i + 1;
  endfunction

  logic        clock = 1'b0;
  logic        clear, MARin, MDRin, req, rw;
  logic [31:0] bus_in;

  logic          busy_v      [NDUT];
  logic          done_v      [NDUT];
  logic [31:0]   mdr_v       [NDUT];
  logic [AW-1:0] mar_v       [NDUT];
  logic [AW-1:0] ram_addr_v  [NDUT];
  logic          ram_read_v  [NDUT];
  logic          ram_write_v [NDUT];
  logic [31:0]   ram_wdata_v [NDUT];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [31:0] mem [512];
    logic [31:0] rdata_q;

    always @(posedge clock) begin
      if (ram_write_v[g]) mem[ram_addr_v[g]] <= ram_wdata_v[g];
      if (ram_read_v[g])  rdata_q <= mem[ram_addr_v[g]];
    end

    mem_access_ctrl #(
      .WAIT_STATES(ws_of(g)),
      .ADDR_W     (AW)
    ) u_dut (
      .clock    (clock),
      .clear    (clear),
      .bus_in   (bus_in),
      .MARin    (MARin),
      .MDRin    (MDRin),
      .req      (req),
      .rw       (rw),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .MDR_out  (mdr_v[g]),
      .MAR_out  (mar_v[g]),
      .ram_addr (ram_addr_v[g]),
      .ram_read (ram_read_v[g]),
      .ram_write(ram_write_v[g]),
      .ram_wdata(ram_wdata_v[g]),
      .ram_rdata(rdata_q)
    );
  end

  typedef struct {
    logic [31:0] mdr;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          w;
    logic [31:0] bus_a;
    logic [31:0] data;
    logic [31:0] exp_mdr;
    logic [AW-1:0] exp_mar;
  } vec_t;

  exp_t          sb [NDUT][$];
  int            rd_cnt [NDUT];
  int            wr_cnt [NDUT];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_wdata;

  task automatic check32(input string name, input int i, input logic [31:0] act,
                         input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc%0d: got %h, expected %h", name, i, cyc, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    for (int i = 0; i < NDUT; i++) begin
      if (ram_read_v[i] || ram_write_v[i]) begin
        check32("strobe_exclusive", i, 32'(ram_read_v[i] & ram_write_v[i]), 32'd0);
        check32("strobe_addr", i, 32'(ram_addr_v[i]), 32'(exp_addr));
        if (ram_write_v[i]) begin
          check32("wdata", i, ram_wdata_v[i], exp_wdata);
          wr_cnt[i]++;
        end else begin
          rd_cnt[i]++;
        end
      end
      if (done_v[i] === 1'b1) begin
        if (sb[i].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done dut%0d cyc%0d: got done=1, expected 0", i, cyc);
        end else begin
          e = sb[i].pop_front();
          check32("done_mdr", i, mdr_v[i], e.mdr);
          check32("done_cycle", i, 32'(cyc), 32'(e.cyc));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
    monitor();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NDUT; i++) begin
      rd_cnt[i] = 0;
      wr_cnt[i] = 0;
    end
  endtask

  // Inputs driven now are sampled at the next edge; done appears lat ticks later.
  task automatic push_all(input bit w, input logic [31:0] mdr, input int offset);
    for (int i = 0; i < NDUT; i++)
      sb[i].push_back('{mdr: mdr, cyc: cyc + offset + (w ? 2 : 3 + ws_of(i))});
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy_v[0] | busy_v[1] | busy_v[2]) && k < 40) begin
      tick();
      k++;
    end
    check32("idle_timeout", 0, 32'(k < 40), 32'd1);
    for (int i = 0; i < NDUT; i++) check32("sb_empty", i, 32'(sb[i].size()), 32'd0);
  endtask

  task automatic drive_idle();
    MARin  = 1'b0;
    MDRin  = 1'b0;
    req    = 1'b0;
    rw     = 1'b0;
    bus_in = 32'h0;
  endtask

  task automatic access(input vec_t v);
    clear_counts();
    exp_addr  = v.bus_a[AW-1:0];
    exp_wdata = v.data;
    if (v.w) begin
      MARin  = 1'b1;
      bus_in = v.bus_a;
      tick();
      MARin  = 1'b0;
      MDRin  = 1'b1;
      bus_in = v.data;
    end else begin
      MARin  = 1'b1;
      bus_in = v.bus_a;
    end
    req = 1'b1;
    rw  = v.w;
    push_all(v.w, v.exp_mdr, 0);
    tick();
    drive_idle();
    wait_idle();
    for (int i = 0; i < NDUT; i++) begin
      check32("mar_after", i, 32'(mar_v[i]), 32'(v.exp_mar));
      check32("mdr_after", i, mdr_v[i], v.exp_mdr);
      check32("rd_strobes", i, 32'(rd_cnt[i]), v.w ? 32'd0 : 32'd1);
      check32("wr_strobes", i, 32'(wr_cnt[i]), v.w ? 32'd1 : 32'd0);
    end
  endtask

  vec_t vt [10];

  initial begin
    vt[0] = '{1'b1, 32'h0000_0087, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 9'h087};
    vt[1] = '{1'b0, 32'h0000_0087, 32'h0,         32'hDEAD_BEEF, 9'h087};
    vt[2] = '{1'b1, 32'h0000_0095, 32'h0000_0022, 32'h0000_0022, 9'h095};
    vt[3] = '{1'b1, 32'h0000_005A, 32'h0000_0012, 32'h0000_0012, 9'h05A};
    vt[4] = '{1'b0, 32'hFFFF_FE95, 32'h0,         32'h0000_0022, 9'h095};
    vt[5] = '{1'b1, 32'h0000_01FF, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 9'h1FF};
    vt[6] = '{1'b1, 32'h0000_0200, 32'h1357_2468, 32'h1357_2468, 9'h000};
    vt[7] = '{1'b0, 32'h0000_01FF, 32'h0,         32'hA5A5_5A5A, 9'h1FF};
    vt[8] = '{1'b0, 32'h0000_0000, 32'h0,         32'h1357_2468, 9'h000};
    vt[9] = '{1'b0, 32'h0000_005A, 32'h0,         32'h0000_0012, 9'h05A};

    exp_addr  = '0;
    exp_wdata = '0;
    clear_counts();
    drive_idle();
    clear = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < NDUT; i++) begin
      check32("rst_busy", i, 32'(busy_v[i]), 32'd0);
      check32("rst_done", i, 32'(done_v[i]), 32'd0);
      check32("rst_mar", i, 32'(mar_v[i]), 32'd0);
      check32("rst_mdr", i, mdr_v[i], 32'd0);
      check32("rst_rd", i, 32'(ram_read_v[i]), 32'd0);
      check32("rst_wr", i, 32'(ram_write_v[i]), 32'd0);
    end
    clear = 1'b1;
    tick();

    for (int n = 0; n < 10; n++) access(vt[n]);

    // Busy lockout: stray loads and req one cycle into a read must change nothing.
    clear_counts();
    exp_addr = 9'h087;
    MARin    = 1'b1;
    bus_in   = 32'h0000_0087;
    req      = 1'b1;
    rw       = 1'b0;
    push_all(1'b0, 32'hDEAD_BEEF, 0);
    tick();
    MARin  = 1'b1;
    MDRin  = 1'b1;
    req    = 1'b1;
    rw     = 1'b1;
    bus_in = 32'h1234_5678;
    tick();
    drive_idle();
    wait_idle();
    repeat (5) tick();
    for (int i = 0; i < NDUT; i++) begin
      check32("lock_mar", i, 32'(mar_v[i]), 32'h087);
      check32("lock_mdr", i, mdr_v[i], 32'hDEAD_BEEF);
      check32("lock_rd", i, 32'(rd_cnt[i]), 32'd1);
      check32("lock_wr", i, 32'(wr_cnt[i]), 32'd0);
    end

    // Reset two cycles into a read: the WAIT_STATES=3 instance is in its wait phase.
    clear_counts();
    exp_addr = 9'h05A;
    MARin    = 1'b1;
    bus_in   = 32'h0000_005A;
    req      = 1'b1;
    rw       = 1'b0;
    tick();
    drive_idle();
    tick();
    check32("pre_rst_busy", 2, 32'(busy_v[2]), 32'd1);
    clear = 1'b0;
    tick();
    clear = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      check32("midrst_busy", i, 32'(busy_v[i]), 32'd0);
      check32("midrst_mar", i, 32'(mar_v[i]), 32'd0);
      check32("midrst_mdr", i, mdr_v[i], 32'd0);
      check32("midrst_strobe", i, 32'(ram_read_v[i] | ram_write_v[i]), 32'd0);
    end
    repeat (6) tick();
    for (int i = 0; i < NDUT; i++) check32("midrst_rd", i, 32'(rd_cnt[i]), 32'd1);
    access(vt[9]);

    // Back-to-back writes with req held: one write per three cycles.
    MARin  = 1'b1;
    bus_in = 32'h0000_0033;
    tick();
    MARin  = 1'b0;
    MDRin  = 1'b1;
    bus_in = 32'h0BAD_F00D;
    tick();
    drive_idle();
    clear_counts();
    exp_addr  = 9'h033;
    exp_wdata = 32'h0BAD_F00D;
    req = 1'b1;
    rw  = 1'b1;
    push_all(1'b1, 32'h0BAD_F00D, 0);
    push_all(1'b1, 32'h0BAD_F00D, 3);
    push_all(1'b1, 32'h0BAD_F00D, 6);
    repeat (7) tick();
    drive_idle();
    wait_idle();
    repeat (4) tick();
    for (int i = 0; i < NDUT; i++) begin
      check32("b2b_wr", i, 32'(wr_cnt[i]), 32'd3);
      check32("b2b_rd", i, 32'(rd_cnt[i]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
